clk_freq_meter: RTL

Measures an incoming slow clock or square-wave signal, the kind produced by the team's clock dividers, against the 100 MHz board clock. It reports two results: the rising-edge count per gate window (frequency) and the cycle count between consecutive rising edges (period). It sits on the consumer side of the divided-clock interface and feeds the display and debug registers, which self-check divider settings.

---
 rtl/clk_meter_pkg.sv | 20 ++
 rtl/clk_freq_meter_sync_edge.sv | 27 ++
 rtl/clk_freq_meter.sv | 110 +++++++++++
 3 files changed

// File: rtl/clk_meter_pkg.sv
// Shared defaults and saturating arithmetic for the clock frequency/period meter.
package clk_meter_pkg;

    localparam int unsigned SYS_FREQ_DEF = 32'd100000000;
    localparam int unsigned CNT_W_DEF    = 32'd32;
    localparam int unsigned SAT_W        = 32'd64;

    // Callers zero-extend to SAT_W and cast the result back to their own width.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] cur,
                                                 input logic [SAT_W-1:0] max_val);
        logic [SAT_W-1:0] res;
        if (cur >= max_val) begin
            res = max_val;
        end else begin
            res = cur + 64'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/clk_freq_meter_sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
module sync_edge (
    input  logic clkin,
    input  logic rstn,
    input  logic din,
    output logic rise
);
    logic sync1_r;
    logic sync2_r;
    logic prev_r;

    // Synchronize din and flag a 0->1 transition one cycle after the second stage.
    always_ff @(posedge clkin) begin
        if (!rstn) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
            rise    <= 1'b0;
        end else begin
            sync1_r <= din;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            rise    <= sync2_r & ~prev_r;
        end
    end

endmodule

// File: rtl/clk_freq_meter.sv
// Counts sigin rising edges per gate window (frequency) and clkin cycles between edges (period).
module clk_freq_meter
    import clk_meter_pkg::*;
#(
    parameter int unsigned SYS_FREQ    = SYS_FREQ_DEF,
    parameter int unsigned GATE_CYCLES = SYS_FREQ,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic             clkin,
    input  logic             rstn,
    input  logic             clken,
    input  logic             sigin,
    output logic [CNT_W-1:0] freq,
    output logic             freq_valid,
    output logic             freq_ovf,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             period_ovf
);
    localparam int unsigned       GATE_W    = (GATE_CYCLES > 32'd1) ? $clog2(GATE_CYCLES) : 32'd1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0]  CNT_ONES  = {CNT_W{1'b1}};
    localparam logic [SAT_W-1:0]  CNT_MAX   = SAT_W'(CNT_ONES);

    logic              rise_s;
    logic              gate_close_s;
    logic              ecnt_full_s;
    logic [CNT_W-1:0]  ecnt_inc_s;
    logic [CNT_W-1:0]  pcnt_inc_s;
    logic [GATE_W-1:0] gcnt_r;
    logic [CNT_W-1:0]  ecnt_r;
    logic              ecnt_sat_r;
    logic [CNT_W-1:0]  pcnt_r;
    logic              armed_r;

    sync_edge u_sync_edge (
        .clkin (clkin),
        .rstn  (rstn),
        .din   (sigin),
        .rise  (rise_s)
    );

    // Saturating next values and window-close decode.
    always_comb begin
        ecnt_inc_s   = CNT_W'(sat_inc(SAT_W'(ecnt_r), CNT_MAX));
        pcnt_inc_s   = CNT_W'(sat_inc(SAT_W'(pcnt_r), CNT_MAX));
        ecnt_full_s  = (ecnt_r == CNT_ONES);
        gate_close_s = (gcnt_r == GATE_LAST);
    end

    // Gate window and edge counter; an edge on the closing cycle belongs to the closing window.
    always_ff @(posedge clkin) begin
        if (!rstn) begin
            gcnt_r     <= {GATE_W{1'b0}};
            ecnt_r     <= {CNT_W{1'b0}};
            ecnt_sat_r <= 1'b0;
            freq       <= {CNT_W{1'b0}};
            freq_valid <= 1'b0;
            freq_ovf   <= 1'b0;
        end else begin
            freq_valid <= 1'b0;
            if (clken) begin
                if (gate_close_s) begin
                    gcnt_r     <= {GATE_W{1'b0}};
                    freq       <= rise_s ? ecnt_inc_s : ecnt_r;
                    freq_ovf   <= ecnt_sat_r | (rise_s & ecnt_full_s);
                    freq_valid <= 1'b1;
                    ecnt_r     <= {CNT_W{1'b0}};
                    ecnt_sat_r <= 1'b0;
                end else begin
                    gcnt_r <= gcnt_r + GATE_W'(1);
                    if (rise_s) begin
                        ecnt_r     <= ecnt_inc_s;
                        ecnt_sat_r <= ecnt_sat_r | ecnt_full_s;
                    end
                end
            end
        end
    end

    // Period counter; the first edge after reset only arms the measurement.
    always_ff @(posedge clkin) begin
        if (!rstn) begin
            pcnt_r       <= {CNT_W{1'b0}};
            armed_r      <= 1'b0;
            period       <= {CNT_W{1'b0}};
            period_valid <= 1'b0;
            period_ovf   <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (clken) begin
                if (rise_s) begin
                    if (armed_r) begin
                        period       <= pcnt_inc_s;
                        period_valid <= 1'b1;
                        period_ovf   <= 1'b0;
                    end
                    pcnt_r  <= {CNT_W{1'b0}};
                    armed_r <= 1'b1;
                end else begin
                    pcnt_r <= pcnt_inc_s;
                    if (pcnt_inc_s == CNT_ONES) begin
                        period_ovf <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
